// File: rtl/riscv_pkg.sv
// Shared RISC-V constants and the fetch buffer entry type used by the fetch stage.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [ILEN-1:0] INSTR_NOP        = 32'h0000_0013;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Instruction addresses are word aligned; the two low bits are dropped.
  function automatic logic [XLEN-1:0] alignWord(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch stage bus: instruction memory port, redirect request and fetch/decode handshake.
interface instr_fetch_if;
  import riscv_pkg::*;

  logic [XLEN-1:0] imem_addr;
  logic [ILEN-1:0] imem_instr;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            fd_valid;
  logic            fd_ready;
  logic [ILEN-1:0] fd_instr;
  logic [XLEN-1:0] fd_pc;

  modport master (
    output imem_addr, fd_valid, fd_instr, fd_pc,
    input  imem_instr, redirect_valid, redirect_target, fd_ready
  );

  modport slave (
    input  imem_addr, fd_valid, fd_instr, fd_pc,
    output imem_instr, redirect_valid, redirect_target, fd_ready
  );

endinterface

// File: rtl/fetch_buffer.sv
// Power-of-two deep FIFO of fetched (instr, pc) pairs with a flush that overrides push and pop.
module fetch_buffer
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  fetch_entry_t           i_push_entry,
  input  logic                   i_pop,
  output logic                   o_valid,
  output fetch_entry_t           o_head,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam fetch_entry_t EMPTY_ENTRY = '{instr: INSTR_NOP, pc: '0};

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_push = i_push && !i_flush;
  assign w_do_pop  = i_pop && !i_flush && (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

  // Storage needs no reset: the head is masked to a NOP whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_entry;
  end

  assign o_valid = (r_count != '0);
  assign o_head  = o_valid ? r_mem[r_rd_ptr] : EMPTY_ENTRY;
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC register, one-deep memory request tracking, squash on redirect and output FIFO.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int              BUF_DEPTH = 2
) (
  input logic            clk,
  input logic            rst_n,
  instr_fetch_if.master  bus
);

  localparam int AW = $clog2(BUF_DEPTH);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_inflight_pc;
  logic            r_inflight;
  logic            w_pop;
  logic            w_push;
  logic            w_issue;
  logic            w_valid;
  logic [AW:0]     w_count;
  logic [AW+1:0]   w_occupancy;
  fetch_entry_t    w_push_entry;
  fetch_entry_t    w_head;

  // Issue only when the response is guaranteed a slot, counting the entry leaving this edge.
  assign w_pop       = w_valid && bus.fd_ready;
  assign w_occupancy = {1'b0, w_count} + (AW+2)'(r_inflight) - (AW+2)'(w_pop);
  assign w_issue     = w_occupancy < (AW+2)'(BUF_DEPTH);
  assign w_push      = r_inflight && !bus.redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= alignWord(RESET_PC);
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (bus.redirect_valid) begin
      r_pc       <= alignWord(bus.redirect_target);
      r_inflight <= 1'b0;
    end else if (w_issue) begin
      r_pc          <= r_pc + XLEN'(4);
      r_inflight    <= 1'b1;
      r_inflight_pc <= r_pc;
    end else begin
      r_inflight <= 1'b0;
    end
  end

  assign w_push_entry.instr = bus.imem_instr;
  assign w_push_entry.pc    = r_inflight_pc;

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buffer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_flush      (bus.redirect_valid),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_valid      (w_valid),
    .o_head       (w_head),
    .o_count      (w_count)
  );

  assign bus.imem_addr = r_pc;
  assign bus.fd_valid  = w_valid;
  assign bus.fd_instr  = w_head.instr;
  assign bus.fd_pc     = w_head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected fetch stream queued by stimulus, popped by a monitor.
module tb_instr_fetch;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  instr_fetch_if bus ();
  instr_fetch_if bus2 ();

  int testsRun = 0;
  int testsFailed = 0;
  int transfers = 0;
  int transfers2 = 0;
  bit wrapSeen = 1'b0;
  exp_t expQ[$];
  logic [31:0] nextPushPc = 32'h0;
  logic [31:0] exp2 = 32'hFFFF_FFF8;

  instr_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) dutWrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    case (addr)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h00A0_0113;
      32'h8:   return 32'h0020_81B3;
      default: return (addr * 32'h9E37_79B1) ^ 32'h0000_0013;
    endcase
  endfunction

  // Instruction memory with one-cycle read latency for both DUTs.
  always @(posedge clk) begin
    bus.imem_instr  <= memWord(bus.imem_addr);
    bus2.imem_instr <= memWord(bus2.imem_addr);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic topUp();
    while (expQ.size() < 16) begin
      expQ.push_back('{pc: nextPushPc, instr: memWord(nextPushPc)});
      nextPushPc = nextPushPc + 32'd4;
    end
  endtask

  task automatic restartStream(input logic [31:0] startPc);
    expQ.delete();
    nextPushPc = startPc & ~32'h3;
    topUp();
  endtask

  task automatic applyStimulus(input bit ready);
    @(negedge clk);
    bus.fd_ready = ready;
    bus.redirect_valid = 1'b0;
    topUp();
  endtask

  task automatic applyRedirect(input logic [31:0] target, input bit readyAtEdge);
    @(negedge clk);
    bus.fd_ready = readyAtEdge;
    bus.redirect_valid = 1'b1;
    bus.redirect_target = target;
    topUp();
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    bus.fd_ready = 1'b1;
    restartStream(target);
    #4 checkOutput("redir_quiet0", 32'(bus.fd_valid), 32'h0);
    @(negedge clk);
    #4 checkOutput("redir_quiet1", 32'(bus.fd_valid), 32'h0);
    @(negedge clk);
    #4;
    checkOutput("redir_first_valid", 32'(bus.fd_valid), 32'h1);
    checkOutput("redir_first_pc", bus.fd_pc, target & ~32'h3);
  endtask

  task automatic releaseReset();
    @(negedge clk);
    rst_n = 1'b1;
    bus.fd_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    restartStream(32'h0);
    #4 checkOutput("lat_edge0", 32'(bus.fd_valid), 32'h0);
    @(negedge clk);
    #4 checkOutput("lat_edge1", 32'(bus.fd_valid), 32'h0);
    @(negedge clk);
    #4;
    checkOutput("lat_edge2_valid", 32'(bus.fd_valid), 32'h1);
    checkOutput("lat_edge2_pc", bus.fd_pc, 32'h0);
  endtask

  // Main monitor: every accepted transfer must match the head of the expected stream.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && bus.fd_valid && bus.fd_ready) begin
        transfers++;
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL mon_unexpected: got pc %h, expected no output", bus.fd_pc);
        end else begin
          e = expQ.pop_front();
          checkOutput("mon_pc", bus.fd_pc, e.pc);
          checkOutput("mon_instr", bus.fd_instr, e.instr);
        end
      end
    end
  end

  // Wrap monitor: the high RESET_PC instance must count up through 0xFFFF_FFFC to 0.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        exp2 = 32'hFFFF_FFF8;
      end else if (bus2.fd_valid) begin
        transfers2++;
        checkOutput("wrap_pc", bus2.fd_pc, exp2);
        checkOutput("wrap_instr", bus2.fd_instr, memWord(exp2));
        if (exp2 == 32'h0) wrapSeen = 1'b1;
        exp2 = exp2 + 32'd4;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] holdPc;
    logic [31:0] holdInstr;
    bus.fd_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = 32'h0;
    bus2.fd_ready = 1'b1;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_target = 32'h0;

    @(negedge clk);
    @(negedge clk);
    #4;
    checkOutput("rst_valid", 32'(bus.fd_valid), 32'h0);
    checkOutput("rst_instr", bus.fd_instr, 32'h0000_0013);
    checkOutput("rst_pc", bus.fd_pc, 32'h0);
    checkOutput("rst_addr", bus.imem_addr, 32'h0);
    checkOutput("rst_addr_wrap", bus2.imem_addr, 32'hFFFF_FFF8);

    releaseReset();
    for (int k = 1; k < 3; k++) begin
      applyStimulus(1'b1);
      #4;
      checkOutput("seq_pc", bus.fd_pc, 32'(k * 4));
      checkOutput("seq_instr", bus.fd_instr, memWord(32'(k * 4)));
    end

    // Decode stalls for five cycles in a steady stream.
    for (int k = 0; k < 4; k++) applyStimulus(1'b1);
    applyStimulus(1'b0);
    #4;
    holdPc = bus.fd_pc;
    holdInstr = bus.fd_instr;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0);
      #4;
      checkOutput("stall_valid", 32'(bus.fd_valid), 32'h1);
      checkOutput("stall_pc", bus.fd_pc, holdPc);
      checkOutput("stall_instr", bus.fd_instr, holdInstr);
      checkOutput("stall_addr", bus.imem_addr, holdPc + 32'd8);
    end
    for (int k = 0; k < 4; k++) applyStimulus(1'b1);

    // Redirect with a full buffer, misaligned target.
    for (int k = 0; k < 3; k++) applyStimulus(1'b0);
    applyRedirect(32'h0000_0043, 1'b0);
    applyStimulus(1'b1);
    #4 checkOutput("redir_second_pc", bus.fd_pc, 32'h0000_0044);

    // Redirect on an edge that also pushes and pops.
    for (int k = 0; k < 4; k++) applyStimulus(1'b1);
    applyRedirect(32'h0000_0200, 1'b1);

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) < 4) applyRedirect($urandom(), 1'($urandom_range(0, 1)));
      else applyStimulus($urandom_range(0, 99) < 70);
    end

    // Asynchronous reset between clock edges.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(bus.fd_valid), 32'h0);
    checkOutput("async_rst_instr", bus.fd_instr, 32'h0000_0013);
    checkOutput("async_rst_pc", bus.fd_pc, 32'h0);
    checkOutput("async_rst_addr", bus.imem_addr, 32'h0);
    expQ.delete();
    releaseReset();
    for (int n = 0; n < 60; n++) applyStimulus($urandom_range(0, 99) < 70);

    @(negedge clk);
    checkOutput("progress", 32'(transfers > 200), 32'h1);
    checkOutput("wrap_seen", 32'(wrapSeen), 32'h1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
